// File: rtl/coproc_job_scheduler.sv
// Round-robin job scheduler in front of a single shared coprocessor.
// Two requesters, one job in flight, responses carry OK / TIMEOUT / ILLEGAL_OP.
module coproc_job_scheduler #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [2:0] req0_op,
    input  logic [1:0] req0_size,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [2:0] req1_op,
    input  logic [1:0] req1_size,
    output logic       req1_ready,
    output logic       cop_start,
    output logic [2:0] cop_op_code,
    output logic [1:0] cop_matrix_size,
    input  logic       cop_done,
    output logic       resp_valid,
    output logic       resp_id,
    output logic [1:0] resp_status,
    input  logic       resp_ready,
    output logic       busy
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESPOND} state_t;

    localparam logic [1:0]  ST_OK      = 2'b00;
    localparam logic [1:0]  ST_TIMEOUT = 2'b01;
    localparam logic [1:0]  ST_ILLEGAL = 2'b10;
    localparam logic [2:0]  OP_ILLEGAL = 3'b111;
    localparam logic [15:0] TERM_CNT   = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        last_q, last_d;
    logic        id_q, id_d;
    logic [1:0]  status_q, status_d;
    logic [2:0]  op_q, op_d;
    logic [1:0]  size_q, size_d;

    logic       grant0, grant1;
    logic [2:0] sel_op;
    logic [1:0] sel_size;

    // Grant is qualified by reset so ready reads 0 while reset is held.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == S_IDLE && !reset) begin
            if (req0_valid && req1_valid) begin
                grant0 = last_q;
                grant1 = !last_q;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
        sel_op   = grant1 ? req1_op   : req0_op;
        sel_size = grant1 ? req1_size : req0_size;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        id_d     = id_q;
        status_d = status_q;
        op_d     = op_q;
        size_d   = size_q;
        case (state_q)
            S_IDLE: begin
                if (grant0 || grant1) begin
                    id_d   = grant1;
                    last_d = grant1;
                    // Illegal ops never reach the coprocessor, so its inputs keep their last job.
                    if (sel_op == OP_ILLEGAL) begin
                        status_d = ST_ILLEGAL;
                        state_d  = S_RESPOND;
                    end else begin
                        op_d    = sel_op;
                        size_d  = sel_size;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cop_done) begin
                    status_d = ST_OK;
                    state_d  = S_RESPOND;
                end else if (cnt_q == TERM_CNT) begin
                    status_d = ST_TIMEOUT;
                    state_d  = S_RESPOND;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_RESPOND: begin
                if (resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            last_q   <= 1'b1;
            id_q     <= 1'b0;
            status_q <= ST_OK;
            op_q     <= '0;
            size_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            id_q     <= id_d;
            status_q <= status_d;
            op_q     <= op_d;
            size_q   <= size_d;
        end
    end

    assign req0_ready      = grant0;
    assign req1_ready      = grant1;
    assign cop_start       = (state_q == S_ISSUE);
    assign cop_op_code     = op_q;
    assign cop_matrix_size = size_q;
    assign resp_valid      = (state_q == S_RESPOND);
    assign resp_id         = id_q;
    assign resp_status     = status_q;
    assign busy            = (state_q != S_IDLE);

endmodule

// File: tb/tb_coproc_job_scheduler.sv
// Directed bench for coproc_job_scheduler: table of jobs plus hand sequences
// for response backpressure and reset in the middle of a job.
module tb_coproc_job_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_valid, req1_valid;
    logic [2:0] req0_op, req1_op;
    logic [1:0] req0_size, req1_size;
    logic       req0_ready, req1_ready;
    logic       cop_start;
    logic [2:0] cop_op_code;
    logic [1:0] cop_matrix_size;
    logic       cop_done;
    logic       resp_valid, resp_id;
    logic [1:0] resp_status;
    logic       resp_ready;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    coproc_job_scheduler #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_size(req0_size), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_size(req1_size), .req1_ready(req1_ready),
        .cop_start(cop_start), .cop_op_code(cop_op_code), .cop_matrix_size(cop_matrix_size),
        .cop_done(cop_done),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_status(resp_status),
        .resp_ready(resp_ready), .busy(busy)
    );

    // dly: negedges after the cop_start cycle at which cop_done rises (0 = never).
    // lat: negedges after the cop_start cycle until resp_valid is seen.
    typedef struct {
        logic       r0v;
        logic [2:0] r0op;
        logic [1:0] r0sz;
        logic       r1v;
        logic [2:0] r1op;
        logic [1:0] r1sz;
        int         dly;
        logic       exp_id;
        logic [1:0] exp_st;
        logic [2:0] exp_op;
        logic [1:0] exp_sz;
        int         exp_lat;
    } vec_t;

    vec_t vecs[9];

    function automatic vec_t mk(logic r0v, logic [2:0] r0op, logic [1:0] r0sz,
                                logic r1v, logic [2:0] r1op, logic [1:0] r1sz,
                                int dly, logic exp_id, logic [1:0] exp_st,
                                logic [2:0] exp_op, logic [1:0] exp_sz, int exp_lat);
        vec_t v;
        v.r0v = r0v; v.r0op = r0op; v.r0sz = r0sz;
        v.r1v = r1v; v.r1op = r1op; v.r1sz = r1sz;
        v.dly = dly; v.exp_id = exp_id; v.exp_st = exp_st;
        v.exp_op = exp_op; v.exp_sz = exp_sz; v.exp_lat = exp_lat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int cnt;
        int starts;
        @(negedge clk);
        req0_valid = v.r0v; req0_op = v.r0op; req0_size = v.r0sz;
        req1_valid = v.r1v; req1_op = v.r1op; req1_size = v.r1sz;
        resp_ready = 1'b1;
        cop_done   = 1'b0;
        #1;
        chk($sformatf("v%0d req0_ready", idx), 32'(req0_ready), 32'(v.exp_id == 1'b0));
        chk($sformatf("v%0d req1_ready", idx), 32'(req1_ready), 32'(v.exp_id == 1'b1));
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk($sformatf("v%0d cop_start", idx), 32'(cop_start), 32'(v.exp_st != 2'b10));
        chk($sformatf("v%0d busy", idx), 32'(busy), 32'd1);
        cnt = 0;
        starts = 0;
        while (!resp_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
            if (cop_start) starts++;
            if (!resp_valid && cnt == v.dly) cop_done = 1'b1;
        end
        chk($sformatf("v%0d latency", idx), 32'(cnt), 32'(v.exp_lat));
        chk($sformatf("v%0d extra_starts", idx), 32'(starts), 32'd0);
        chk($sformatf("v%0d resp_id", idx), 32'(resp_id), 32'(v.exp_id));
        chk($sformatf("v%0d resp_status", idx), 32'(resp_status), 32'(v.exp_st));
        chk($sformatf("v%0d cop_op_code", idx), 32'(cop_op_code), 32'(v.exp_op));
        chk($sformatf("v%0d cop_matrix_size", idx), 32'(cop_matrix_size), 32'(v.exp_sz));
        @(negedge clk);
        cop_done = 1'b0;
        chk($sformatf("v%0d idle_busy", idx), 32'(busy), 32'd0);
        chk($sformatf("v%0d idle_resp_valid", idx), 32'(resp_valid), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " cop_start"}, 32'(cop_start), 32'd0);
        chk({tag, " cop_op_code"}, 32'(cop_op_code), 32'd0);
        chk({tag, " cop_matrix_size"}, 32'(cop_matrix_size), 32'd0);
        chk({tag, " resp_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, " resp_id"}, 32'(resp_id), 32'd0);
        chk({tag, " resp_status"}, 32'(resp_status), 32'd0);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " req0_ready"}, 32'(req0_ready), 32'd0);
        chk({tag, " req1_ready"}, 32'(req1_ready), 32'd0);
    endtask

    initial begin
        int cnt;
        int bad_valid, bad_id, bad_st, bad_busy, bad_rdy;

        // Pointer starts at requester 1, so the first contended grant goes to 0.
        vecs[0] = mk(1, 3'd3, 2'd2, 0, 3'd0, 2'd0, 5, 0, 2'b00, 3'd3, 2'd2, 6);
        vecs[1] = mk(1, 3'd1, 2'd0, 1, 3'd2, 2'd1, 1, 1, 2'b00, 3'd2, 2'd1, 2);
        vecs[2] = mk(1, 3'd4, 2'd3, 1, 3'd5, 2'd0, 3, 0, 2'b00, 3'd4, 2'd3, 4);
        vecs[3] = mk(1, 3'd6, 2'd1, 1, 3'd0, 2'd2, 2, 1, 2'b00, 3'd0, 2'd2, 3);
        vecs[4] = mk(0, 3'd0, 2'd0, 1, 3'd7, 2'd3, 0, 1, 2'b10, 3'd0, 2'd2, 0);
        vecs[5] = mk(1, 3'd2, 2'd1, 1, 3'd3, 2'd0, 0, 0, 2'b01, 3'd2, 2'd1, 9);
        vecs[6] = mk(1, 3'd5, 2'd0, 1, 3'd1, 2'd3, 8, 1, 2'b00, 3'd1, 2'd3, 9);
        vecs[7] = mk(1, 3'd6, 2'd2, 0, 3'd0, 2'd0, 9, 0, 2'b01, 3'd6, 2'd2, 9);
        vecs[8] = mk(1, 3'd7, 2'd1, 0, 3'd0, 2'd0, 0, 0, 2'b10, 3'd6, 2'd2, 0);

        reset = 1'b1;
        req0_valid = 1'b1; req0_op = 3'd3; req0_size = 2'd1;
        req1_valid = 1'b1; req1_op = 3'd2; req1_size = 2'd2;
        cop_done = 1'b0;
        resp_ready = 1'b0;
        #1;
        chk_reset_outputs("por");
        repeat (2) @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        reset = 1'b0;

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // Backpressure: response must hold for 10 cycles while requests knock.
        @(negedge clk);
        req1_valid = 1'b1; req1_op = 3'd1; req1_size = 2'd1;
        resp_ready = 1'b0;
        #1;
        chk("bp req1_ready", 32'(req1_ready), 32'd1);
        @(negedge clk);
        req1_valid = 1'b0;
        cop_done = 1'b1;
        cnt = 0;
        while (!resp_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk("bp latency", 32'(cnt), 32'd2);
        cop_done = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        bad_valid = 0; bad_id = 0; bad_st = 0; bad_busy = 0; bad_rdy = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            req0_op = 3'(k);
            #1;
            if (resp_valid !== 1'b1) bad_valid++;
            if (resp_id !== 1'b1) bad_id++;
            if (resp_status !== 2'b00) bad_st++;
            if (busy !== 1'b1) bad_busy++;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0) bad_rdy++;
        end
        chk("bp resp_valid_drops", 32'(bad_valid), 32'd0);
        chk("bp resp_id_changes", 32'(bad_id), 32'd0);
        chk("bp resp_status_changes", 32'(bad_st), 32'd0);
        chk("bp busy_drops", 32'(bad_busy), 32'd0);
        chk("bp ready_while_busy", 32'(bad_rdy), 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        chk("bp release busy", 32'(busy), 32'd0);

        // Reset mid-WAIT: job vanishes, pointer goes back to favouring requester 0.
        @(negedge clk);
        req0_valid = 1'b1; req0_op = 3'd3; req0_size = 2'd2;
        req1_valid = 1'b0;
        @(negedge clk);
        req0_valid = 1'b0;
        chk("rst cop_start", 32'(cop_start), 32'd1);
        @(negedge clk);
        chk("rst in_wait busy", 32'(busy), 32'd1);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        cop_done = 1'b1;
        reset = 1'b1;
        #1;
        chk_reset_outputs("rst");
        @(negedge clk);
        reset = 1'b0;
        cop_done = 1'b0;
        #1;
        chk("rst no_response", 32'(resp_valid), 32'd0);
        chk("rst grant req0_ready", 32'(req0_ready), 32'd1);
        chk("rst grant req1_ready", 32'(req1_ready), 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst end idle", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/coproc_job_scheduler.md
COPROC_JOB_SCHEDULER -- requirements
Module: coproc_job_scheduler

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 1024, number of WAIT cycles allowed before a job is declared timed out (legal range 2..65535).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 (HPS bridge) has a job pending.
REQ-005 req0_op  input  3  requester 0 coprocessor op_code.
REQ-006 req0_size  input  2  requester 0 matrix_size code (00=2x2, 01=3x3, 10=4x4, 11=5x5).
REQ-007 req0_ready  output  1  job from requester 0 accepted this cycle.
REQ-008 req1_valid, req1_op, req1_size, req1_ready  same widths, directions and meanings, for requester 1 (secondary/DMA port).
REQ-009 cop_start  output  1  one-cycle pulse launching the shared coprocessor.
REQ-010 cop_op_code  output  3  op_code driven to the coprocessor.
REQ-011 cop_matrix_size  output  2  matrix_size driven to the coprocessor.
REQ-012 cop_done  input  1  coprocessor completion level (process_Done).
REQ-013 resp_valid  output  1  job response available.
REQ-014 resp_id  output  1  requester that owns the response (0 or 1).
REQ-015 resp_status  output  2  00=OK, 01=TIMEOUT, 10=ILLEGAL_OP, 11 never driven.
REQ-016 resp_ready  input  1  response consumer accepts the response.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 FSM states: IDLE, ISSUE, WAIT, RESPOND; one job in flight at a time.
REQ-019 IDLE: a job is accepted when reqN_valid and reqN_ready are both high; reqN_ready is combinational, high only in IDLE for the granted requester; at most one ready high per cycle.
REQ-020 Arbitration: round-robin; if both requesters are valid, grant goes to the one not granted last; after reset, requester 0 has priority.
REQ-021 The last-grant pointer updates on acceptance, not on response.
REQ-022 On acceptance: latch op, size and id; if op == 3'b111, go to RESPOND with status ILLEGAL_OP and never pulse cop_start; otherwise go to ISSUE.
REQ-023 ISSUE: cop_start=1 for exactly one cycle; clear the timeout counter; go to WAIT next cycle.
REQ-024 cop_op_code and cop_matrix_size hold the latched job values from ISSUE through the end of WAIT, and keep their last value in all other states.
REQ-025 WAIT: cop_done sampled every cycle; if high, go to RESPOND with status OK.
REQ-026 WAIT: counter increments every cycle cop_done is low; when counter == TIMEOUT_CYCLES-1 and cop_done is low, go to RESPOND with status TIMEOUT.
REQ-027 Simultaneous cop_done and timeout terminal count: OK wins.
REQ-028 cop_done is ignored in IDLE, ISSUE and RESPOND.
REQ-029 RESPOND: resp_valid=1 with resp_id and resp_status stable until resp_ready is sampled high; then go to IDLE in the same edge.
REQ-030 While busy, incoming requests are held off (ready=0); request inputs may change freely without effect.
REQ-031 Latency: accept-edge to cop_start high = 1 cycle; cop_done high in WAIT to resp_valid high = 1 cycle.
REQ-032 Counter is 16 bits and never wraps (terminal count ends WAIT).

Reset
REQ-033 reset asserted at any time, including mid-job: FSM -> IDLE, counter=0, last-grant pointer = requester 1 (so requester 0 wins first), latched op/size/id=0.
REQ-034 Output values while in reset: cop_start=0, cop_op_code=0, cop_matrix_size=0, resp_valid=0, resp_id=0, resp_status=00, busy=0, req0_ready=0, req1_ready=0.
REQ-035 A job interrupted by reset produces no response; the coprocessor result is discarded.

Verification
REQ-036 req0_valid=1, op=3, size=2, cop_done rises 5 cycles after cop_start, resp_ready=1 -> one cop_start pulse, cop_op_code=3, cop_matrix_size=2, response id=0, status=00.
REQ-037 Both requesters valid continuously for 4 jobs -> grants alternate 0,1,0,1.
REQ-038 req1 op=7 -> cop_start never asserts; response id=1, status=10 on the cycle after acceptance.
REQ-039 TIMEOUT_CYCLES=8, cop_done held low -> resp_status=01 exactly 8 cycles after entering WAIT; a same-cycle done at the terminal count gives 00.
REQ-040 resp_ready held low 10 cycles in RESPOND -> resp_valid, resp_id and resp_status are stable, busy=1, and both ready outputs stay 0.
REQ-041 reset pulsed in WAIT -> all outputs go to reset values immediately, no response; next simultaneous request is granted to requester 0.
